// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the full-speed USB transmit bit engine.
// Line encodings are {dp, dm}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam logic [1:0] LINE_J       = 2'b10;
  localparam logic [1:0] LINE_K       = 2'b01;
  localparam logic [1:0] LINE_SE0     = 2'b00;
  localparam int         EOP_SE0_BITS = 2;

  // NRZI level 1 is J, level 0 is K.
  function automatic logic [1:0] nrzi_line(input logic lvl);
    return lvl ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags clock positions in the bit.
// Latency: combinational flags from the registered count; no backpressure.
// Ports: enable advances the count, clear forces it to 0; bit_strobe = last clock of the bit,
//        pre_strobe = clock before that, first_clk = first clock of the bit.
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic bit_strobe,
  output logic pre_strobe,
  output logic first_clk
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] PRE  = TW'(CLKS_PER_BIT - 2);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_strobe = enable && (cnt == LAST);
  assign pre_strobe = enable && (cnt == PRE);
  assign first_clk  = (cnt == '0);

endmodule

// File: rtl/usb_tx_encoder.sv
// Full-speed USB TX bit engine: SYNC prepend, LSB-first serialise, bit stuffing, NRZI, EOP.
// Latency: first SYNC bit on the line the cycle after tx_start; every bit held CLKS_PER_BIT clocks.
// Backpressure: one byte fetched per bit-7 window; a missing byte pulses tx_error and ends with EOP.
// Ports: tx_start/tx_data/tx_data_valid/tx_last in; tx_data_ready, tx_busy, tx_done, tx_error
//        status out; dplus_out/dminus_out registered pad drives.
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ready,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

  tx_state_t         state, nxt_state;
  logic              nrzi;
  logic [ONES_W-1:0] ones;
  logic [2:0]        bit_idx, nxt_idx;
  logic [6:0]        sr;        // bits still to send of the current byte, next one in sr[0]
  logic [7:0]        nb;
  logic              nb_last, cur_last, fetched;
  logic              bit_strobe, pre_strobe, first_clk;
  logic              nxt_bit, nxt_lvl, load_byte, shift_on, advance;
  logic              fetch_slot, fetch_win;

  usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (state != IDLE),
    .clear      (state == IDLE),
    .bit_strobe (bit_strobe),
    .pre_strobe (pre_strobe),
    .first_clk  (first_clk)
  );

  // Bit 7 of SYNC or of a non-last byte is where the following byte must be fetched.
  // The last clock is excluded so an underrun can be flagged on it.
  assign fetch_slot = (bit_idx == 3'd7) && ((state == SYNC) || ((state == DATA) && !cur_last));
  assign fetch_win  = fetch_slot && !fetched && !bit_strobe;

  assign advance = (state == IDLE) ? tx_start : bit_strobe;
  assign nxt_lvl = nxt_bit ? nrzi : ~nrzi;

  // Content of the next bit period, applied on the bit boundary.
  always_comb begin
    nxt_state = state;
    nxt_idx   = bit_idx;
    nxt_bit   = 1'b0;
    load_byte = 1'b0;
    shift_on  = 1'b0;
    case (state)
      IDLE: begin
        nxt_state = SYNC;
        nxt_idx   = 3'd0;
        nxt_bit   = SYNC_BYTE[0];
      end
      SYNC, DATA, STUFF: begin
        // ones is zero in STUFF, so a stuff bit is never followed by another.
        if (ones == ONES_W'(STUFF_LIMIT)) begin
          nxt_state = STUFF;
        end else if (bit_idx != 3'd7) begin
          // SYNC never reaches the stuff limit mid-byte, so STUFF always resumes DATA.
          nxt_state = (state == SYNC) ? SYNC : DATA;
          nxt_idx   = bit_idx + 3'd1;
          nxt_bit   = sr[0];
          shift_on  = 1'b1;
        end else if (fetched && !cur_last) begin
          nxt_state = DATA;
          nxt_idx   = 3'd0;
          nxt_bit   = nb[0];
          load_byte = 1'b1;
        end else begin
          nxt_state = EOP_SE0;
          nxt_idx   = 3'd0;
        end
      end
      EOP_SE0: begin
        nxt_idx = bit_idx + 3'd1;
        if (bit_idx == 3'(EOP_SE0_BITS - 1)) nxt_state = EOP_J;
      end
      EOP_J:   nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      nrzi          <= 1'b1;
      ones          <= '0;
      bit_idx       <= '0;
      sr            <= '0;
      nb            <= '0;
      nb_last       <= 1'b0;
      cur_last      <= 1'b0;
      fetched       <= 1'b0;
      dplus_out     <= 1'b1;
      dminus_out    <= 1'b0;
      tx_busy       <= 1'b0;
      tx_data_ready <= 1'b0;
      tx_done       <= 1'b0;
      tx_error      <= 1'b0;
    end else begin
      tx_data_ready <= 1'b0;
      tx_error      <= 1'b0;
      tx_done       <= (state == EOP_J) && pre_strobe;

      // fetched covers one bit-7 window; it must survive a trailing stuff bit
      // so the byte boundary after the stuff still sees the capture.
      if (first_clk && (state != STUFF)) fetched <= 1'b0;
      if (fetch_win && tx_data_valid) begin
        fetched       <= 1'b1;
        nb            <= tx_data;
        nb_last       <= tx_last;
        tx_data_ready <= 1'b1;
      end
      if (fetch_slot && !fetched && pre_strobe && !tx_data_valid) tx_error <= 1'b1;

      if (advance) begin
        state   <= nxt_state;
        bit_idx <= nxt_idx;
        if (state == IDLE) begin
          sr       <= SYNC_BYTE[7:1];
          cur_last <= 1'b0;
          tx_busy  <= 1'b1;
        end
        if (shift_on) sr <= {1'b0, sr[6:1]};
        if (load_byte) begin
          sr       <= nb[7:1];
          cur_last <= nb_last;
        end
        case (nxt_state)
          SYNC, DATA, STUFF: begin
            nrzi                    <= nxt_lvl;
            {dplus_out, dminus_out} <= nrzi_line(nxt_lvl);
            ones                    <= nxt_bit ? ones + 1'b1 : '0;
          end
          EOP_SE0: {dplus_out, dminus_out} <= LINE_SE0;
          EOP_J:   {dplus_out, dminus_out} <= LINE_J;
          default: begin
            nrzi                    <= 1'b1;
            ones                    <= '0;
            {dplus_out, dminus_out} <= LINE_J;
            tx_busy                 <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
module tb_usb_tx_encoder;

  localparam int CPB = 8;
  localparam int SL  = 6;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_data_ready, dplus_out, dminus_out, tx_busy, tx_done, tx_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .STUFF_LIMIT(SL)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_last       (tx_last),
    .tx_data_ready (tx_data_ready),
    .dplus_out     (dplus_out),
    .dminus_out    (dminus_out),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_error      (tx_error)
  );

  // Packet description: n data bytes, and per fetch k (0 = during SYNC) the
  // offset into the bit-7 window at which the source raises valid
  // (0 = valid already waiting; >= CPB-1 means too late -> underrun).
  logic [7:0] pb [8];
  int         off [9];
  int         n;

  // Reference: line level per bit period, ready pulse cycles, error/done cycles.
  logic [1:0] q [$];
  int         rq [$];
  int         a_t [9];
  int         err_t, done_t;
  logic       lvl;
  int         ones;

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    if (!b) lvl = ~lvl;
    q.push_back(lvl ? LJ : LK);
    ones = b ? ones + 1 : 0;
    if (ones == SL) begin
      lvl = ~lvl;
      q.push_back(lvl ? LJ : LK);
      ones = 0;
    end
  endtask

  task automatic build_model();
    logic [7:0] b;
    int s;
    bit stop;
    q.delete();
    rq.delete();
    lvl = 1'b1;
    ones = 0;
    err_t = -1;
    stop = 0;
    for (int i = 0; i < 9; i++) a_t[i] = 1000000;
    for (int k = 0; k <= n && !stop; k++) begin
      b = (k == 0) ? 8'h80 : pb[k-1];
      for (int j = 0; j < 8; j++) begin
        if (j == 7 && k < n) begin
          s = q.size() * CPB;
          if (off[k] <= CPB - 2) begin
            a_t[k] = (off[k] == 0) ? 0 : s + off[k];
            rq.push_back(s + off[k] + 1);
          end else begin
            a_t[k] = s + off[k];
            err_t  = s + CPB - 1;
            stop   = 1;
          end
        end
        send_bit(b[j]);
      end
    end
    q.push_back(LSE0);
    q.push_back(LSE0);
    q.push_back(LJ);
    done_t = q.size() * CPB - 1;
  endtask

  // t counts cycles from the first SYNC bit. ign_t: cycle with a stray tx_start
  // (-1 none, -2 = the tx_done cycle). abort_t: cycle to pull reset (-1 none).
  task automatic run_pkt(input int ign_t, input int abort_t);
    int k, ri, rcnt, ign;
    logic [1:0] expl;
    logic exp_rdy;
    build_model();
    ign = (ign_t == -2) ? done_t : ign_t;
    @(negedge clk);
    tx_start = 1'b1;
    k = 0; ri = 0; rcnt = 0;
    for (int t = 0; t <= done_t + 4; t++) begin
      @(negedge clk);
      tx_start = (t == ign);
      if (t == abort_t) begin
        n_rst = 1'b0;
        #1;
        chk("abort_line", t, {dplus_out, dminus_out}, LJ);
        chk("abort_busy", t, tx_busy, 1'b0);
        tx_start = 1'b0;
        tx_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_hold", t, {dplus_out, dminus_out}, LJ);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        return;
      end
      expl = (t / CPB < q.size()) ? q[t / CPB] : LJ;
      chk("line", t, {dplus_out, dminus_out}, expl);
      chk("busy", t, tx_busy, (t <= done_t));
      chk("done", t, tx_done, (t == done_t));
      chk("error", t, tx_error, (t == err_t));
      exp_rdy = (ri < rq.size()) && (rq[ri] == t);
      chk("ready", t, tx_data_ready, exp_rdy);
      if (exp_rdy) ri++;
      if (tx_data_ready) begin
        tx_data_valid = 1'b0;
        k++;
        rcnt++;
      end
      if (!tx_data_valid && k < n && t >= a_t[k]) begin
        tx_data_valid = 1'b1;
        tx_data = pb[k];
        tx_last = (k == n - 1);
      end
    end
    tx_start = 1'b0;
    tx_data_valid = 1'b0;
    tx_last = 1'b0;
    chk("ready_count", -1, rcnt, rq.size());
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int r;
    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_line", -1, {dplus_out, dminus_out}, LJ);
    chk("rst_busy", -1, tx_busy, 1'b0);
    n_rst = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      chk("idle_line", t, {dplus_out, dminus_out}, LJ);
      chk("idle_busy", t, tx_busy, 1'b0);
      chk("idle_ready", t, tx_data_ready, 1'b0);
      chk("idle_done", t, tx_done, 1'b0);
      chk("idle_error", t, tx_error, 1'b0);
    end

    // Single 0x00
    n = 1; pb[0] = 8'h00; off[0] = 0;
    run_pkt(-1, -1);
    chk("len_00", -1, done_t + 1, 152);

    // Single 0xFF with a stuff bit after the fifth data one
    n = 1; pb[0] = 8'hFF; off[0] = 0;
    run_pkt(-1, -1);
    chk("len_ff", -1, done_t + 1, 160);

    // Two bytes, second offered 3 clocks into its bit-7 window
    n = 2; pb[0] = 8'hA5; pb[1] = 8'h3C; off[0] = 0; off[1] = 3;
    run_pkt(-1, -1);

    // Underrun: nothing offered during SYNC
    n = 1; pb[0] = 8'h55; off[0] = 99;
    run_pkt(-1, -1);

    // Reset during 0xA5 bit 3, then a clean 0x00 packet
    n = 1; pb[0] = 8'hA5; off[0] = 0;
    run_pkt(-1, (8 + 3) * CPB + 2);
    n = 1; pb[0] = 8'h00; off[0] = 0;
    run_pkt(-1, -1);

    // tx_start coinciding with tx_done and mid-packet must be ignored
    n = 1; pb[0] = 8'h3C; off[0] = 0;
    run_pkt(-2, -1);
    n = 2; pb[0] = 8'h7E; pb[1] = 8'hC3; off[0] = 0; off[1] = 0;
    run_pkt(40, -1);

    // Randomised packets
    for (int p = 0; p < 12; p++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        r = $urandom;
        case ($urandom_range(0, 2))
          0: pb[i] = r[7:0];
          1: pb[i] = 8'hFF;
          default: pb[i] = r[7:0] | 8'h7E;
        endcase
        off[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : 0;
      end
      run_pkt(($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 80), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
